mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 24 ++
 rtl/mdu.sv | 153 +++++++++++++++
 tb/tb_mdu.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared CPU definitions for the multiply/divide unit: opcode encodings,
// default latencies and FSM state type.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'b0000,
    OP_MULTU = 4'b0001,
    OP_DIV   = 4'b0010,
    OP_DIVU  = 4'b0011,
    OP_MFHI  = 4'b0100,
    OP_MFLO  = 4'b0101,
    OP_MTHI  = 4'b0110,
    OP_MTLO  = 4'b0111
  } mdu_op_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit: result computed at issue into temp regs, committed to
// HI/LO after a fixed latency so the pipeline sees multi-cycle timing.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [3:0]  MDU_op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_result
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, lo_q, hi_t, lo_t;
  logic        dz_q;

  logic        is_mul, is_div, is_sdiv, div_zero;
  logic        accept, commit, mt_hi, mt_lo;

  logic signed [31:0] a_s, b_s;
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] num, den, q_u, r_u, res_hi, res_lo;

  function automatic logic [31:0] mag(input logic signed [31:0] v);
    return v[31] ? $unsigned(-v) : $unsigned(v);
  endfunction

  assign a_s    = $signed(A);
  assign b_s    = $signed(B);
  assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign prod_u = {32'b0, A} * {32'b0, B};

  assign is_mul   = (MDU_op == OP_MULT) || (MDU_op == OP_MULTU);
  assign is_sdiv  = (MDU_op == OP_DIV);
  assign is_div   = is_sdiv || (MDU_op == OP_DIVU);
  assign div_zero = is_div && (B == 32'd0);

  // Signed divide works on magnitudes so MIN/-1 wraps to MIN without overflow traps.
  assign num = is_sdiv ? mag(a_s) : A;
  assign den = is_sdiv ? mag(b_s) : B;
  assign q_u = (den == 32'd0) ? 32'd0 : num / den;
  assign r_u = (den == 32'd0) ? 32'd0 : num % den;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (MDU_op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        res_lo = (A[31] ^ B[31]) ? (32'd0 - q_u) : q_u;
        res_hi = A[31] ? (32'd0 - r_u) : r_u;
      end
      OP_DIVU: begin
        res_lo = q_u;
        res_hi = r_u;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    mt_hi   = 1'b0;
    mt_lo   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && (is_mul || is_div)) begin
          accept  = 1'b1;
          state_d = ST_BUSY;
          cnt_d   = is_mul ? MULT_N : DIV_N;
        end else if (start) begin
          mt_hi = (MDU_op == OP_MTHI);
          mt_lo = (MDU_op == OP_MTLO);
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          commit  = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_t <= 32'd0;
      lo_t <= 32'd0;
      dz_q <= 1'b0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      if (accept) begin
        dz_q <= div_zero;
        if (!div_zero) begin
          hi_t <= res_hi;
          lo_t <= res_lo;
        end
      end
      // Completion has priority over MT writes; a zero divisor commits nothing.
      if (commit) begin
        if (!dz_q) begin
          hi_q <= hi_t;
          lo_q <= lo_t;
        end
      end else begin
        if (mt_hi) hi_q <= A;
        if (mt_lo) lo_q <= A;
      end
    end
  end

  assign busy = (state_q == ST_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;

  always_comb begin
    MDU_result = 32'd0;
    if (MDU_op == OP_MFHI) MDU_result = hi_q;
    else if (MDU_op == OP_MFLO) MDU_result = lo_q;
  end

endmodule

// File: tb/tb_mdu.sv
// Randomized bench for mdu against an arithmetic reference model of HI/LO.
module tb_mdu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [3:0]  MDU_op = 4'hF;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] HI, LO, MDU_result;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  mdu dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .MDU_op(MDU_op), .start(start),
    .busy(busy), .HI(HI), .LO(LO), .MDU_result(MDU_result)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int latency(input logic [3:0] op);
    if (op <= 4'd1) return 5;
    if (op <= 4'd3) return 10;
    return 0;
  endfunction

  task automatic model_apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      4'd0: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
      4'd1: begin pu = ua * ub; exp_hi = pu[63:32]; exp_lo = pu[31:0]; end
      4'd2: if (b != 0) begin q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0]; end
      4'd3: if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
      4'd6: exp_hi = a;
      4'd7: exp_lo = a;
      default: ;
    endcase
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_hi"}, HI, exp_hi);
    chk({tag, "_lo"}, LO, exp_lo);
    MDU_op = 4'd4;
    #1 chk({tag, "_mfhi"}, MDU_result, exp_hi);
    MDU_op = 4'd5;
    #1 chk({tag, "_mflo"}, MDU_result, exp_lo);
    MDU_op = 4'd8;
    #1 chk({tag, "_nop_res"}, MDU_result, 0);
    MDU_op = 4'hF;
  endtask

  // Issue one op with start for a single cycle; inputs change 1ns after the edge.
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int c;
    logic [31:0] old_hi;
    old_hi = exp_hi;
    A = a; B = b; MDU_op = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; MDU_op = 4'hF;
    c = 0;
    while (busy && c < 20) begin
      c++;
      if (c == 1) chk({tag, "_hold"}, HI, old_hi);
      @(posedge clk); #1;
    end
    chk({tag, "_busy_cycles"}, c, latency(op));
    model_apply(op, a, b);
    check_regs(tag);
  endtask

  initial begin
    int c;
    logic [3:0] op;
    logic [31:0] a, b;

    #3;
    chk("rst_busy", busy, 0);
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    issue("mult", 4'd0, 32'hFFFF_FFFF, 32'd2);
    chk("mult_hi_const", HI, 32'hFFFF_FFFF);
    chk("mult_lo_const", LO, 32'hFFFF_FFFE);
    issue("multu", 4'd1, 32'hFFFF_FFFF, 32'd2);
    chk("multu_hi_const", HI, 32'h1);
    issue("div", 4'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_lo_const", LO, 32'hFFFF_FFFD);
    chk("div_hi_const", HI, 32'hFFFF_FFFF);
    issue("divu", 4'd3, 32'd7, 32'd2);
    chk("divu_lo_const", LO, 32'd3);
    issue("div_ovf", 4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo_const", LO, 32'h8000_0000);
    issue("mthi11", 4'd6, 32'h11, 32'd0);
    issue("mtlo22", 4'd7, 32'h22, 32'd0);
    issue("div0", 4'd2, 32'd99, 32'd0);
    chk("div0_hi_const", HI, 32'h11);
    chk("div0_lo_const", LO, 32'h22);
    issue("divu0", 4'd3, 32'd99, 32'd0);
    issue("mthi", 4'd6, 32'h1234, 32'd0);
    issue("mtlo", 4'd7, 32'h5678, 32'd0);
    issue("mfhi_start", 4'd4, 32'hDEAD, 32'd1);

    // Asynchronous reset in the third busy cycle of a multiply.
    A = 32'd1000; B = 32'd1000; MDU_op = 4'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; MDU_op = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hi", HI, 0);
    chk("abort_lo", LO, 0);
    exp_hi = '0; exp_lo = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_busy_after", busy, 0);
    check_regs("abort_late");
    issue("post_rst_mult", 4'd0, 32'd3, 32'hFFFF_FFFE);

    // A MULT arriving in the fourth busy cycle of a DIV must be dropped.
    A = 32'd100; B = 32'd7; MDU_op = 4'd2; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; MDU_op = 4'hF;
    c = 1;
    repeat (3) begin @(posedge clk); #1 if (busy) c++; end
    A = 32'h0BAD_0BAD; B = 32'h1234; MDU_op = 4'd0; start = 1'b1;
    while (c < 20) begin
      @(posedge clk); #1 start = 1'b0; MDU_op = 4'hF;
      if (!busy) break;
      c++;
    end
    chk("ign_busy_cycles", c, 10);
    model_apply(4'd2, 32'd100, 32'd7);
    @(posedge clk); #1;
    chk("ign_no_restart", busy, 0);
    check_regs("ign");

    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
      issue($sformatf("rnd%0d_op%0d", i, op), op, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
